// File: rtl/pe_ctrl.sv
// pe_ctrl: sequencer that clears a convolution PE, loads its kernel, then runs one MAC pass and OFM write per window
module pe_ctrl #(
  parameter int         FILTER_WORDS = 4,
  parameter int         MAC_LEN      = 16,
  parameter logic [7:0] FILTER_BASE  = 8'd0,
  parameter logic [7:0] OFM_BASE     = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_windows,
  input  logic       win_ready,
  output logic       win_take,
  output logic       memRead,
  output logic [7:0] memAddr,
  output logic       winRst,
  output logic       wEnFilter,
  output logic       readEnmac,
  output logic       addEn,
  output logic       wrofm,
  output logic [5:0] filterCount,
  output logic [5:0] macCount,
  output logic       ofm_we,
  output logic [7:0] ofm_addr,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, CLR, LOAD_F, WAIT_WIN, MAC, WRITE, DONE} state_t;
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] win_q, win_d, nw_q, nw_d;
  logic       rd_step, wr_step;
  // state, step counter, window index and latched window count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      nw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      nw_q    <= nw_d;
    end
  end
  // next-state sequencing; the step counter is left at 0 on every exit so each phase starts fresh
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    nw_d    = nw_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLR;
        nw_d    = num_windows;
        win_d   = '0;
      end
      CLR: begin
        cnt_d   = '0;
        state_d = (nw_q == 8'd0) ? DONE : LOAD_F;
      end
      LOAD_F: begin
        cnt_d   = (cnt_q == 6'(FILTER_WORDS)) ? 6'd0 : cnt_q + 6'd1;
        state_d = (cnt_q == 6'(FILTER_WORDS)) ? WAIT_WIN : LOAD_F;
      end
      WAIT_WIN: if (win_ready) begin
        state_d = MAC;
        cnt_d   = '0;
      end
      MAC: begin
        cnt_d   = (cnt_q == 6'(MAC_LEN)) ? 6'd0 : cnt_q + 6'd1;
        state_d = (cnt_q == 6'(MAC_LEN)) ? WRITE : MAC;
      end
      WRITE: begin
        state_d = (win_q == nw_q - 8'd1) ? DONE : WAIT_WIN;
        win_d   = (win_q == nw_q - 8'd1) ? win_q : win_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // strobes decoded from registered state; memory data lags memRead by one cycle, hence the k-1 write address
  assign rd_step     = (state_q == LOAD_F) && (cnt_q < 6'(FILTER_WORDS));
  assign wr_step     = (state_q == LOAD_F) && (cnt_q != 6'd0);
  assign memRead     = rd_step;
  assign memAddr     = rd_step ? FILTER_BASE + {2'b00, cnt_q} : 8'd0;
  assign wEnFilter   = wr_step;
  assign filterCount = wr_step ? cnt_q - 6'd1 : (state_q == MAC) ? cnt_q : 6'd0;
  assign macCount    = (state_q == MAC) ? cnt_q : 6'd0;
  assign readEnmac   = (state_q == MAC);
  assign addEn       = (state_q == MAC);
  assign winRst      = (state_q == CLR);
  assign wrofm       = (state_q == CLR) || (state_q == WRITE);
  assign ofm_we      = (state_q == WRITE);
  assign ofm_addr    = (state_q == WRITE) ? OFM_BASE + win_q : 8'd0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign win_take    = (state_q == WAIT_WIN) && win_ready;
endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: randomized self-checking bench for pe_ctrl against a cycle-offset job model
module tb_pe_ctrl;
  localparam int F = 4;
  localparam int M = 16;
  logic       clk = 0, rst = 0, start = 0, win_ready = 0;
  logic [7:0] num_windows = 0;
  logic       win_take, memRead, winRst, wEnFilter, readEnmac, addEn, wrofm, ofm_we, busy, done;
  logic [7:0] memAddr, ofm_addr;
  logic [5:0] filterCount, macCount;
  int tests = 0, fails = 0;

  pe_ctrl #(.FILTER_WORDS(F), .MAC_LEN(M)) dut (
    .clk(clk), .rst(rst), .start(start), .num_windows(num_windows), .win_ready(win_ready),
    .win_take(win_take), .memRead(memRead), .memAddr(memAddr), .winRst(winRst),
    .wEnFilter(wEnFilter), .readEnmac(readEnmac), .addEn(addEn), .wrofm(wrofm),
    .filterCount(filterCount), .macCount(macCount), .ofm_we(ofm_we), .ofm_addr(ofm_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] outs();
    return {win_take, memRead, memAddr, winRst, wEnFilter, readEnmac, addEn, wrofm,
            filterCount, macCount, ofm_we, ofm_addr, busy, done};
  endfunction

  // Runs one job from the current IDLE cycle (cycle 0 = start sampled). pct: win_ready probability,
  // stall: forced-low cycles at the start of each wait, noise: spurious start/num_windows changes,
  // hold: keep start high at the end for a back-to-back job.
  task automatic run_job(input int nw, input int pct, input int stall, input bit noise, input bit hold,
                         output int first_ofm, output int done_c);
    int c = 0, take = -1, w = 0, waited = 0, acc = 0, ofms = 0, d;
    bit fin = 0, in_wait;
    bit e_wt, e_mr, e_clr, e_we, e_rm, e_ae, e_wo, e_ow, e_bz, e_dn;
    logic [7:0] e_ma, e_oa;
    logic [5:0] e_fc, e_mc;
    logic [37:0] exp_v, got_v;
    first_ofm = -1;
    done_c = -1;
    start = 1;
    num_windows = 8'(nw);
    while (!fin && c < 3000) begin
      if (c > 0) begin
        start = hold | (noise && $urandom_range(0, 3) == 0);
        if (noise) num_windows = 8'($urandom);
      end
      in_wait = (nw > 0) && (c >= F + 3) && (take < 0);
      win_ready = (in_wait && waited < stall) ? 1'b0 : ($urandom_range(1, 100) <= pct);
      @(negedge clk);
      {e_wt, e_mr, e_clr, e_we, e_rm, e_ae, e_wo, e_ow, e_bz, e_dn} = '0;
      e_ma = 0; e_oa = 0; e_fc = 0; e_mc = 0;
      if (c == 1) begin
        e_clr = 1; e_wo = 1; e_bz = 1;
      end else if (c >= 2 && nw == 0) begin
        e_bz = 1; e_dn = 1; fin = 1; done_c = c;
      end else if (c >= 2 && c <= F + 2) begin
        e_bz = 1;
        if (c <= F + 1) begin e_mr = 1; e_ma = 8'(c - 2); end
        if (c >= 3) begin e_we = 1; e_fc = 6'(c - 3); end
      end else if (c > F + 2) begin
        e_bz = 1;
        if (take < 0) begin
          e_wt = win_ready;
          if (win_ready) begin take = c; waited = 0; end else waited++;
        end else begin
          d = c - take;
          if (d <= M + 1) begin
            e_rm = 1; e_ae = 1; e_fc = 6'(d - 1); e_mc = 6'(d - 1);
          end else if (d == M + 2) begin
            e_ow = 1; e_wo = 1; e_oa = 8'(w);
            if (first_ofm < 0) first_ofm = c;
            if (w < nw - 1) begin w++; take = -1; end
          end else begin
            e_dn = 1; fin = 1; done_c = c;
          end
        end
      end
      exp_v = {e_wt, e_mr, e_ma, e_clr, e_we, e_rm, e_ae, e_wo, e_fc, e_mc, e_ow, e_oa, e_bz, e_dn};
      got_v = outs();
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL outputs nw=%0d cycle=%0d got=%h expected=%h", nw, c, got_v, exp_v);
      end
      if (ofm_we) begin
        ofms++;
        tests++;
        if (acc !== 2 * M) begin
          fails++;
          $display("FAIL ofm_data cycle=%0d got=%0d expected=%0d", c, acc, 2 * M);
        end
      end
      if (wrofm) acc = 0;
      else if (addEn && macCount != 0) acc += 2;
      @(posedge clk);
      #1;
      c++;
    end
    if (!hold) start = 0;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL job_timeout nw=%0d cycles=%0d", nw, c);
    end
    tests++;
    if (ofms !== nw) begin
      fails++;
      $display("FAIL ofm_count nw=%0d got=%0d expected=%0d", nw, ofms, nw);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #1;
    tests++;
    if (outs() !== 38'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%h expected=0", outs());
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    tests++;
    if (outs() !== 38'd0) begin
      fails++;
      $display("FAIL idle_after_reset got=%h expected=0", outs());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int fo, dc;
    run_job(2, 100, 0, 0, 0, fo, dc);
    tests++;
    if (fo !== F + M + 5) begin
      fails++;
      $display("FAIL first_ofm_cycle got=%0d expected=%0d", fo, F + M + 5);
    end
    tests++;
    if (dc !== F + 2 * M + 9) begin
      fails++;
      $display("FAIL done_cycle got=%0d expected=%0d", dc, F + 2 * M + 9);
    end
  endtask

  task automatic test_zero_windows();
    int fo, dc;
    run_job(0, 100, 0, 0, 0, fo, dc);
    tests++;
    if (dc !== 2) begin
      fails++;
      $display("FAIL zero_done_cycle got=%0d expected=2", dc);
    end
  endtask

  task automatic test_stall();
    int fo, dc;
    run_job(2, 100, 5, 0, 0, fo, dc);
    tests++;
    if (fo !== F + M + 10) begin
      fails++;
      $display("FAIL stall_first_ofm got=%0d expected=%0d", fo, F + M + 10);
    end
  endtask

  task automatic test_start_ignored();
    int fo, dc;
    run_job(3, 100, 0, 1, 0, fo, dc);
  endtask

  task automatic test_mid_reset();
    int fo, dc;
    start = 1;
    num_windows = 8'd3;
    @(posedge clk);
    #1 start = 0;
    repeat (11) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (readEnmac !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_mac got=%b expected=1", readEnmac);
    end
    rst = 1;
    #1;
    tests++;
    if (outs() !== 38'd0) begin
      fails++;
      $display("FAIL async_reset_outputs got=%h expected=0", outs());
    end
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 30; i++) begin
      win_ready = 1'($urandom);
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle cycle=%0d done=%b busy=%b expected 0 0", i, done, busy);
      end
      @(posedge clk);
      #1;
    end
    run_job(2, 100, 0, 0, 0, fo, dc);
  endtask

  task automatic test_random();
    int fo, dc;
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 4), $urandom_range(30, 100), $urandom_range(0, 3), 1, 0, fo, dc);
  endtask

  task automatic test_back_to_back();
    int fo, dc;
    run_job(1, 100, 0, 0, 1, fo, dc);
    run_job(2, 70, 1, 0, 1, fo, dc);
    run_job(0, 100, 0, 0, 1, fo, dc);
    run_job(1, 100, 0, 0, 0, fo, dc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_windows();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
